// File: rtl/kv_store_engine.sv
// kv_store_engine: valid/ready key-value store with GET/PUT/DEL/FLUSH and round-robin eviction
module kv_store_engine #(
  parameter int NUM_ENTRIES = 16,
  parameter int KEY_WIDTH = 16,
  parameter int VALUE_WIDTH = 64,
  localparam int CNT_W = $clog2(NUM_ENTRIES + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [1:0]             req_op_i,
  input  logic [KEY_WIDTH-1:0]   req_key_i,
  input  logic [VALUE_WIDTH-1:0] req_val_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic                   rsp_hit_o,
  output logic                   rsp_evict_o,
  output logic [VALUE_WIDTH-1:0] rsp_val_o,
  output logic [CNT_W-1:0]       used_count_o,
  output logic                   full_o
);
  localparam int IDX_W = $clog2(NUM_ENTRIES);
  localparam logic [1:0] OP_GET = 2'd0, OP_PUT = 2'd1, OP_DEL = 2'd2, OP_FLUSH = 2'd3;
  typedef enum logic [1:0] {IDLE, LOOKUP, EXEC, RESP} state_t;
  state_t state, state_d;
  logic [1:0] op_q;
  logic [KEY_WIDTH-1:0] key_q;
  logic [VALUE_WIDTH-1:0] val_q;
  logic [NUM_ENTRIES-1:0] valid, match_vec, match_q;
  logic [KEY_WIDTH-1:0] keys [NUM_ENTRIES];
  logic [VALUE_WIDTH-1:0] vals [NUM_ENTRIES];
  logic [IDX_W-1:0] hit_idx, free_idx, hit_idx_q, free_idx_q, victim_ptr, idx;
  logic hit, inc, dec, evict, flush, rd;
  logic [CNT_W-1:0] cnt_d;
  always_comb begin
    match_vec = '0;
    hit_idx = '0;
    free_idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      match_vec[i] = valid[i] && keys[i] == key_q;
      if (match_vec[i]) hit_idx = IDX_W'(i);
      if (!valid[i]) free_idx = IDX_W'(i);
    end
  end
  always_comb begin
    hit = |match_q;
    flush = op_q == OP_FLUSH;
    inc = op_q == OP_PUT && !hit && !full_o;
    evict = op_q == OP_PUT && !hit && full_o;
    dec = op_q == OP_DEL && hit;
    idx = hit ? hit_idx_q : !full_o ? free_idx_q : victim_ptr;
    rd = op_q == OP_PUT ? evict : hit && !flush;
    cnt_d = flush ? '0 : inc ? used_count_o + CNT_W'(1) : dec ? used_count_o - CNT_W'(1) : used_count_o;
  end
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = req_valid_i ? LOOKUP : IDLE;
      LOOKUP:  state_d = EXEC;
      EXEC:    state_d = RESP;
      default: state_d = rsp_ready_i ? IDLE : RESP;
    endcase
  end
  assign req_ready_o = state == IDLE && !rst;
  assign rsp_valid_o = state == RESP;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      valid <= '0;
      used_count_o <= '0;
      full_o <= 1'b0;
      victim_ptr <= '0;
      rsp_hit_o <= 1'b0;
      rsp_evict_o <= 1'b0;
      rsp_val_o <= '0;
    end else begin
      state <= state_d;
      if (state == IDLE && req_valid_i) begin
        op_q <= req_op_i;
        key_q <= req_key_i;
        val_q <= req_val_i;
      end
      if (state == LOOKUP) begin
        match_q <= match_vec;
        hit_idx_q <= hit_idx;
        free_idx_q <= free_idx;
      end
      if (state == EXEC) begin
        rsp_hit_o <= flush || hit;
        rsp_evict_o <= evict;
        rsp_val_o <= rd ? vals[idx] : '0;
        used_count_o <= cnt_d;
        full_o <= cnt_d == CNT_W'(NUM_ENTRIES);
        if (flush) valid <= '0;
        else if (inc) valid[idx] <= 1'b1;
        else if (dec) valid[idx] <= 1'b0;
        if (flush) victim_ptr <= '0;
        else if (evict) victim_ptr <= victim_ptr == IDX_W'(NUM_ENTRIES - 1) ? '0 : victim_ptr + IDX_W'(1);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && state == EXEC && op_q == OP_PUT) begin
      keys[idx] <= key_q;
      vals[idx] <= val_q;
    end
  end
  always_ff @(posedge clk) assert (used_count_o <= CNT_W'(NUM_ENTRIES));
endmodule

// File: tb/tb_kv_store_engine.sv
// tb_kv_store_engine: directed self-checking bench for kv_store_engine with 4 entries
module tb_kv_store_engine;
  localparam int N = 4;
  localparam logic [1:0] GET = 2'd0, PUT = 2'd1, DEL = 2'd2, FLUSH = 2'd3;
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, rsp_ready = 1'b1;
  logic [1:0] req_op = '0;
  logic [15:0] req_key = '0;
  logic [63:0] req_val = '0;
  logic req_ready_o, rsp_valid_o, rsp_hit_o, rsp_evict_o, full_o;
  logic [63:0] rsp_val_o;
  logic [2:0] used_count_o;
  int n_chk = 0, n_fail = 0;
  logic h, e;
  logic [63:0] rv;
  kv_store_engine #(.NUM_ENTRIES(N), .KEY_WIDTH(16), .VALUE_WIDTH(64)) dut (
    .clk(clk), .rst(rst), .req_valid_i(req_valid), .req_ready_o(req_ready_o),
    .req_op_i(req_op), .req_key_i(req_key), .req_val_i(req_val),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready), .rsp_hit_o(rsp_hit_o),
    .rsp_evict_o(rsp_evict_o), .rsp_val_o(rsp_val_o), .used_count_o(used_count_o), .full_o(full_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic do_op(input logic [1:0] o, input logic [15:0] k, input logic [63:0] v, input int hold,
                       output logic oh, output logic oe, output logic [63:0] ov);
    int w, lat;
    @(negedge clk);
    req_valid = 1'b1; req_op = o; req_key = k; req_val = v; rsp_ready = hold == 0;
    w = 0;
    while (!req_ready_o && w < 20) begin @(negedge clk); w++; end
    chk("accept", 64'(w < 20), 64'd1);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid_o && lat < 20) begin @(negedge clk); lat++; end
    chk("latency", 64'(lat), 64'd3);
    oh = rsp_hit_o; oe = rsp_evict_o; ov = rsp_val_o;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("stall_valid", 64'(rsp_valid_o), 64'd1);
      chk("stall_ready", 64'(req_ready_o), 64'd0);
      chk("stall_hit", 64'(rsp_hit_o), 64'(oh));
      chk("stall_val", rsp_val_o, ov);
    end
    rsp_ready = 1'b1;
  endtask
  task automatic t_op(input string tag, input logic [1:0] o, input logic [15:0] k, input logic [63:0] v,
                      input logic eh, input logic ee, input logic [63:0] ev, input int ec);
    logic th, te;
    logic [63:0] tv;
    do_op(o, k, v, 0, th, te, tv);
    chk({tag, "_hit"}, 64'(th), 64'(eh));
    chk({tag, "_evict"}, 64'(te), 64'(ee));
    chk({tag, "_val"}, tv, ev);
    chk({tag, "_count"}, 64'(used_count_o), 64'(ec));
    chk({tag, "_full"}, 64'(full_o), 64'(ec == N));
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_valid", 64'(rsp_valid_o), 64'd0);
    chk("rst_ready", 64'(req_ready_o), 64'd0);
    chk("rst_count", 64'(used_count_o), 64'd0);
    chk("rst_val", rsp_val_o, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", 64'(req_ready_o), 64'd1);
    t_op("get_empty", GET, 16'h0001, 64'h0, 0, 0, 64'h0, 0);
    t_op("put1", PUT, 16'h0001, 64'hDEAD_BEEF, 0, 0, 64'h0, 1);
    t_op("get1", GET, 16'h0001, 64'h0, 1, 0, 64'hDEAD_BEEF, 1);
    t_op("put1_upd", PUT, 16'h0001, 64'h5, 1, 0, 64'h0, 1);
    t_op("get1_upd", GET, 16'h0001, 64'h0, 1, 0, 64'h5, 1);
    t_op("put2", PUT, 16'h0002, 64'h22, 0, 0, 64'h0, 2);
    t_op("put3", PUT, 16'h0003, 64'h33, 0, 0, 64'h0, 3);
    t_op("put4", PUT, 16'h0004, 64'h44, 0, 0, 64'h0, 4);
    t_op("put5_ev0", PUT, 16'h0005, 64'h55, 0, 1, 64'h5, 4);
    t_op("get1_gone", GET, 16'h0001, 64'h0, 0, 0, 64'h0, 4);
    t_op("get5", GET, 16'h0005, 64'h0, 1, 0, 64'h55, 4);
    t_op("put6_ev1", PUT, 16'h0006, 64'h66, 0, 1, 64'h22, 4);
    t_op("put7_ev2", PUT, 16'h0007, 64'h77, 0, 1, 64'h33, 4);
    t_op("put8_ev3", PUT, 16'h0008, 64'h88, 0, 1, 64'h44, 4);
    t_op("put9_wrap", PUT, 16'h0009, 64'h99, 0, 1, 64'h55, 4);
    t_op("del6", DEL, 16'h0006, 64'h0, 1, 0, 64'h66, 3);
    t_op("del6_again", DEL, 16'h0006, 64'h0, 0, 0, 64'h0, 3);
    t_op("putA_fill", PUT, 16'h000A, 64'hAA, 0, 0, 64'h0, 4);
    t_op("putB_evA", PUT, 16'h000B, 64'hBB, 0, 1, 64'hAA, 4);
    t_op("del8", DEL, 16'h0008, 64'h0, 1, 0, 64'h88, 3);
    t_op("del9", DEL, 16'h0009, 64'h0, 1, 0, 64'h99, 2);
    t_op("putC_s0", PUT, 16'h000C, 64'hCC, 0, 0, 64'h0, 3);
    t_op("putD_s3", PUT, 16'h000D, 64'hDD, 0, 0, 64'h0, 4);
    t_op("putE_ev2", PUT, 16'h000E, 64'hEE, 0, 1, 64'h77, 4);
    t_op("putF_ev3", PUT, 16'h000F, 64'hFF, 0, 1, 64'hDD, 4);
    t_op("put10_ev0", PUT, 16'h0010, 64'h100, 0, 1, 64'hCC, 4);
    t_op("flush", FLUSH, 16'h0000, 64'h0, 1, 0, 64'h0, 0);
    t_op("getB_flushed", GET, 16'h000B, 64'h0, 0, 0, 64'h0, 0);
    t_op("getE_flushed", GET, 16'h000E, 64'h0, 0, 0, 64'h0, 0);
    t_op("re_put1", PUT, 16'h0001, 64'h11, 0, 0, 64'h0, 1);
    t_op("re_put2", PUT, 16'h0002, 64'h22, 0, 0, 64'h0, 2);
    t_op("re_put3", PUT, 16'h0003, 64'h33, 0, 0, 64'h0, 3);
    t_op("re_put4", PUT, 16'h0004, 64'h44, 0, 0, 64'h0, 4);
    t_op("re_put5_ev0", PUT, 16'h0005, 64'h55, 0, 1, 64'h11, 4);
    do_op(GET, 16'h0002, 64'h0, 10, h, e, rv);
    chk("stall_get_hit", 64'(h), 64'd1);
    chk("stall_get_val", rv, 64'h22);
    t_op("after_stall", GET, 16'h0003, 64'h0, 1, 0, 64'h33, 4);
    @(negedge clk);
    req_valid = 1'b1; req_op = PUT; req_key = 16'h0077; req_val = 64'h7777;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_valid", 64'(rsp_valid_o), 64'd0);
    chk("abort_ready", 64'(req_ready_o), 64'd0);
    chk("abort_count", 64'(used_count_o), 64'd0);
    rst = 1'b0;
    t_op("abort_get77", GET, 16'h0077, 64'h0, 0, 0, 64'h0, 0);
    t_op("abort_get2", GET, 16'h0002, 64'h0, 0, 0, 64'h0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
